// File: rtl/memory_access_stage.sv
// MEM stage of the 5-stage MIPS pipe: EX/MEM register, data RAM with multi-cycle
// access, front-of-pipe stall, and the MEM/WB register feeding writeback.
module memory_access_stage #(
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        validE,
  input  logic        RegWriteE,
  input  logic        MemToRegE,
  input  logic        MemWriteE,
  input  logic [31:0] AluOutE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  writeRegE,
  output logic        stallM,
  output logic        validM,
  output logic        RegWriteM,
  output logic [31:0] AluOutM,
  output logic [4:0]  writeRegM,
  output logic        validW,
  output logic        RegWriteW,
  output logic        MemToRegW,
  output logic [31:0] AluOutW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  writeRegW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] LOAD_CNT = CW'(MEM_LATENCY - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam bit MULTI_CYCLE = (MEM_LATENCY > 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, stateNext;
  logic [CW-1:0]  remaining, remainingNext;
  logic           MemToRegM, MemWriteM;
  logic [31:0]    WriteDataM;
  logic [31:0]    ram [DEPTH];

  logic          memOpE, advance, storeEn;
  logic [AW-1:0] addrM;

  assign memOpE  = validE & (MemToRegE | MemWriteE);
  assign advance = (state == IDLE);
  assign stallM  = (state == BUSY);
  assign addrM   = AluOutM[AW+1:2];
  // The M instruction leaves on any non-stalled edge; reset gating stops an aborted store.
  assign storeEn = advance & validM & MemWriteM & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state     <= stateNext;
      remaining <= remainingNext;
    end
  end

  always_comb begin
    stateNext     = state;
    remainingNext = remaining;
    case (state)
      IDLE: begin
        if (memOpE && MULTI_CYCLE) begin
          stateNext     = BUSY;
          remainingNext = LOAD_CNT;
        end
      end
      BUSY: begin
        remainingNext = remaining - ONE;
        if (remaining == ONE) stateNext = IDLE;
      end
      default: begin
        stateNext     = IDLE;
        remainingNext = '0;
      end
    endcase
  end

  // EX/MEM boundary: bubbles carry no control bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemToRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      AluOutM    <= '0;
      WriteDataM <= '0;
      writeRegM  <= '0;
    end else if (advance) begin
      validM     <= validE;
      RegWriteM  <= validE & RegWriteE;
      MemToRegM  <= validE & MemToRegE;
      MemWriteM  <= validE & MemWriteE;
      AluOutM    <= AluOutE;
      WriteDataM <= WriteDataE;
      writeRegM  <= writeRegE;
    end
  end

  always_ff @(posedge clk) begin
    if (storeEn) ram[addrM] <= WriteDataM;
  end

  // MEM/WB boundary: read sees the pre-store word on a combined load/store
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validW    <= 1'b0;
      RegWriteW <= 1'b0;
      MemToRegW <= 1'b0;
      AluOutW   <= '0;
      ReadDataW <= '0;
      writeRegW <= '0;
    end else if (stallM) begin
      validW    <= 1'b0;
      RegWriteW <= 1'b0;
      MemToRegW <= 1'b0;
      AluOutW   <= '0;
      ReadDataW <= '0;
      writeRegW <= '0;
    end else begin
      validW    <= validM;
      RegWriteW <= RegWriteM & validM;
      MemToRegW <= MemToRegM;
      AluOutW   <= AluOutM;
      ReadDataW <= MemToRegM ? ram[addrM] : '0;
      writeRegW <= writeRegM;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: one instance at MEM_LATENCY=3, one at 1.
module tb_memory_access_stage;

  logic        clk, reset;
  logic        validE, RegWriteE, MemToRegE, MemWriteE;
  logic [31:0] AluOutE, WriteDataE;
  logic [4:0]  writeRegE;

  logic        stall3, validM3, RegWriteM3, validW3, RegWriteW3, MemToRegW3;
  logic [31:0] AluOutM3, AluOutW3, ReadDataW3;
  logic [4:0]  writeRegM3, writeRegW3;
  logic        stall1, validM1, RegWriteM1, validW1, RegWriteW1, MemToRegW1;
  logic [31:0] AluOutM1, AluOutW1, ReadDataW1;
  logic [4:0]  writeRegM1, writeRegW1;

  int checks = 0;
  int errors = 0;

  memory_access_stage #(.DEPTH(256), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .validE(validE), .RegWriteE(RegWriteE),
    .MemToRegE(MemToRegE), .MemWriteE(MemWriteE), .AluOutE(AluOutE),
    .WriteDataE(WriteDataE), .writeRegE(writeRegE), .stallM(stall3),
    .validM(validM3), .RegWriteM(RegWriteM3), .AluOutM(AluOutM3),
    .writeRegM(writeRegM3), .validW(validW3), .RegWriteW(RegWriteW3),
    .MemToRegW(MemToRegW3), .AluOutW(AluOutW3), .ReadDataW(ReadDataW3),
    .writeRegW(writeRegW3));

  memory_access_stage #(.DEPTH(256), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .validE(validE), .RegWriteE(RegWriteE),
    .MemToRegE(MemToRegE), .MemWriteE(MemWriteE), .AluOutE(AluOutE),
    .WriteDataE(WriteDataE), .writeRegE(writeRegE), .stallM(stall1),
    .validM(validM1), .RegWriteM(RegWriteM1), .AluOutM(AluOutM1),
    .writeRegM(writeRegM1), .validW(validW1), .RegWriteW(RegWriteW1),
    .MemToRegW(MemToRegW1), .AluOutW(AluOutW1), .ReadDataW(ReadDataW1),
    .writeRegW(writeRegW1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        v, rw, m2r, mw;
    logic [31:0] alu, wd;
    logic [4:0]  wr;
    logic        xv, xrw, xm2r;
    logic [31:0] xalu, xrd;
    logic [4:0]  xwr;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  function automatic vec_t mk(logic v, logic rw, logic m2r, logic mw,
                              logic [31:0] alu, logic [31:0] wd, logic [4:0] wr,
                              logic xv, logic xrw, logic xm2r, logic [31:0] xrd);
    vec_t r;
    r.v = v; r.rw = rw; r.m2r = m2r; r.mw = mw;
    r.alu = alu; r.wd = wd; r.wr = wr;
    r.xv = xv; r.xrw = xrw; r.xm2r = xm2r;
    r.xalu = alu; r.xrd = xrd; r.xwr = wr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setE(input logic v, input logic rw, input logic m2r, input logic mw,
                      input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    validE = v; RegWriteE = rw; MemToRegE = m2r; MemWriteE = mw;
    AluOutE = alu; WriteDataE = wd; writeRegE = wr;
  endtask

  task automatic bubble();
    setE(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 1, 32'h400, 32'hA5A5A5A5, 5'd0,  1, 0, 0, 32'h0);
    tbl[1]  = mk(1, 1, 1, 0, 32'h000, 32'h0,        5'd7,  1, 1, 1, 32'hA5A5A5A5);
    tbl[2]  = mk(1, 1, 1, 0, 32'h403, 32'h0,        5'd8,  1, 1, 1, 32'hA5A5A5A5);
    tbl[3]  = mk(1, 0, 0, 1, 32'h008, 32'h1,        5'd0,  1, 0, 0, 32'h0);
    tbl[4]  = mk(1, 1, 1, 0, 32'h008, 32'h0,        5'd9,  1, 1, 1, 32'h1);
    tbl[5]  = mk(0, 1, 0, 1, 32'h008, 32'hFFFFFFFF, 5'd2,  0, 0, 0, 32'h0);
    tbl[6]  = mk(1, 1, 1, 0, 32'h008, 32'h0,        5'd10, 1, 1, 1, 32'h1);
    tbl[7]  = mk(1, 1, 0, 0, 32'hCAFE, 32'h0,       5'd31, 1, 1, 0, 32'h0);
    tbl[8]  = mk(1, 1, 1, 1, 32'h008, 32'h55,       5'd11, 1, 1, 1, 32'h1);
    tbl[9]  = mk(1, 1, 1, 0, 32'h008, 32'h0,        5'd12, 1, 1, 1, 32'h55);
    tbl[10] = mk(1, 0, 0, 0, 32'h77,  32'h0,        5'd0,  1, 0, 0, 32'h0);

    reset = 1'b1;
    bubble();
    step();
    step();
    chk("reset stall3", 32'(stall3), 32'h0);
    chk("reset validM3", 32'(validM3), 32'h0);
    chk("reset validW3", 32'(validW3), 32'h0);
    chk("reset AluOutW1", AluOutW1, 32'h0);
    chk("reset writeRegW1", 32'(writeRegW1), 32'h0);
    reset = 1'b0;

    // ALU op: latched at first edge, in W after second
    setE(1, 1, 0, 0, 32'h1234, 32'h0, 5'd5);
    step();
    bubble();
    chk("alu AluOutM3", AluOutM3, 32'h1234);
    chk("alu writeRegM3", 32'(writeRegM3), 32'd5);
    chk("alu RegWriteM1", 32'(RegWriteM1), 32'h1);
    chk("alu early validW3", 32'(validW3), 32'h0);
    step();
    chk("alu AluOutW3", AluOutW3, 32'h1234);
    chk("alu writeRegW3", 32'(writeRegW3), 32'd5);
    chk("alu RegWriteW3", 32'(RegWriteW3), 32'h1);
    chk("alu AluOutW1", AluOutW1, 32'h1234);
    chk("alu validW1", 32'(validW1), 32'h1);

    reset = 1'b1;
    #1;
    chk("midreset AluOutW1", AluOutW1, 32'h0);
    chk("midreset RegWriteW3", 32'(RegWriteW3), 32'h0);
    chk("midreset validW3", 32'(validW3), 32'h0);
    #1;
    reset = 1'b0;

    // Latency 3 store: two stall cycles, then leaves on the third edge
    setE(1, 0, 0, 1, 32'h10, 32'hDEADBEEF, 5'd0);
    step();
    bubble();
    chk("st stall c1", 32'(stall3), 32'h1);
    chk("st bubbleW c1", 32'(validW3), 32'h0);
    step();
    chk("st stall c2", 32'(stall3), 32'h1);
    chk("st bubbleW c2", 32'(validW3), 32'h0);
    step();
    chk("st stall released", 32'(stall3), 32'h0);
    chk("st still in M", 32'(validM3), 32'h1);
    step();
    chk("st validW3", 32'(validW3), 32'h1);
    chk("st RegWriteW3", 32'(RegWriteW3), 32'h0);

    setE(0, 0, 0, 1, 32'h10, 32'h00000BAD, 5'd0);
    step();
    chk("bubble no stall", 32'(stall3), 32'h0);
    setE(1, 1, 1, 0, 32'h10, 32'h0, 5'd3);
    step();
    bubble();
    chk("bubble validW3", 32'(validW3), 32'h0);
    chk("ld stall", 32'(stall3), 32'h1);
    step();
    step();
    chk("ld stall released", 32'(stall3), 32'h0);
    step();
    chk("ld ReadDataW3", ReadDataW3, 32'hDEADBEEF);
    chk("ld MemToRegW3", 32'(MemToRegW3), 32'h1);
    chk("ld writeRegW3", 32'(writeRegW3), 32'd3);

    // Reset during BUSY aborts the pending store
    setE(1, 0, 0, 1, 32'h20, 32'h11111111, 5'd0);
    step();
    bubble();
    repeat (3) step();
    chk("pre store done", 32'(validW3), 32'h1);
    setE(1, 0, 0, 1, 32'h20, 32'h22222222, 5'd0);
    step();
    bubble();
    chk("abort stall before", 32'(stall3), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort stall drop", 32'(stall3), 32'h0);
    chk("abort validM3", 32'(validM3), 32'h0);
    step();
    reset = 1'b0;
    setE(1, 1, 1, 0, 32'h20, 32'h0, 5'd4);
    step();
    bubble();
    repeat (3) step();
    chk("abort old word kept", ReadDataW3, 32'h11111111);
    chk("abort load validW3", 32'(validW3), 32'h1);

    // Table on the latency-1 instance: one bundle per cycle, W lags by one edge
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) setE(tbl[i].v, tbl[i].rw, tbl[i].m2r, tbl[i].mw,
                       tbl[i].alu, tbl[i].wd, tbl[i].wr);
      else bubble();
      step();
      chk($sformatf("vec%0d stall1", i), 32'(stall1), 32'h0);
      if (i >= 1) begin
        chk($sformatf("vec%0d validW", i - 1), 32'(validW1), 32'(tbl[i-1].xv));
        chk($sformatf("vec%0d RegWriteW", i - 1), 32'(RegWriteW1), 32'(tbl[i-1].xrw));
        chk($sformatf("vec%0d MemToRegW", i - 1), 32'(MemToRegW1), 32'(tbl[i-1].xm2r));
        if (tbl[i-1].xv) begin
          chk($sformatf("vec%0d AluOutW", i - 1), AluOutW1, tbl[i-1].xalu);
          chk($sformatf("vec%0d writeRegW", i - 1), 32'(writeRegW1), 32'(tbl[i-1].xwr));
          if (tbl[i-1].xm2r)
            chk($sformatf("vec%0d ReadDataW", i - 1), ReadDataW1, tbl[i-1].xrd);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Pipeline MEM stage of the 5-stage MIPS core, directly downstream of the execute stage. It captures the execute stage's result bundle into an EX/MEM register, performs word loads/stores against an internal data RAM with a configurable access latency, stalls the front of the pipe while an access is in flight, and presents a registered MEM/WB bundle to writeback. It also exports the current M-stage destination and result for the forwarding unit.

## Interface
- DEPTH, 256: data RAM size in 32-bit words; power of two, at least 4.
- MEM_LATENCY, 2: cycles a load/store occupies the M stage; at least 1.
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all pipeline state
- validE  in  1  execute bundle holds a real instruction
- RegWriteE, MemToRegE, MemWriteE  in  1 each  control bits from execute
- AluOutE  in  32  ALU result / effective byte address
- WriteDataE  in  32  store data (forwarded rt value)
- writeRegE  in  5  destination register
- stallM  out  1  upstream must hold its bundle and not advance
- validM, RegWriteM  out  1 each  EX/MEM register contents, for forwarding
- AluOutM  out  32  EX/MEM ALU result, for forwarding
- writeRegM  out  5  EX/MEM destination, for forwarding
- validW, RegWriteW, MemToRegW  out  1 each  MEM/WB control
- AluOutW, ReadDataW  out  32 each  MEM/WB ALU result and load data
- writeRegW  out  5  MEM/WB destination

## Operation
- Word address = AluOutM[log2(DEPTH)+1:2]. Bits [1:0] are ignored. Higher bits are ignored, so addresses wrap modulo DEPTH words.
- Memory op = validM & (MemToRegM | MemWriteM). A memory op stays in M for MEM_LATENCY cycles. Any other instruction, or a bubble, stays for exactly 1 cycle.
- FSM states:
  - IDLE: M holds a non-memory op or a bubble.
  - BUSY: a memory op is in flight; a down-counter `remaining` loads MEM_LATENCY-1 on entry.
- FSM transitions:
  - IDLE→BUSY: a memory op is latched into EX/MEM and MEM_LATENCY>1.
  - In BUSY, the counter decrements each cycle.
  - BUSY→IDLE: on the edge where `remaining`==1.
- stallM = (state==BUSY).
- While stallM=1:
  - the EX/MEM register holds its value; E inputs are ignored.
  - MEM/WB loads a bubble: validW=0, RegWriteW=0, MemToRegW=0. Data fields are don't-care, driven 0.
- Leaving edge (the edge on which the M instruction advances to W):
  - Store: RAM[addr] <= WriteDataM, exactly once, only if validM.
  - Load: ReadDataW <= RAM[addr], the value before any write on the same edge.
  - Other fields copy from M to W. RegWriteW = RegWriteM & validM.
- MemToRegM=1 with MemWriteM=1 on the same instruction: the store is performed and ReadDataW returns the old word.
- validE=0 is a bubble: all control bits in M are forced to 0.
- RAM contents are not cleared by reset and power up undefined. A bench initialises memory by stores.

## Timing
- Reset values: stallM=0. All valid and control outputs are 0. All data outputs are 0, writeReg outputs 5'd0. FSM=IDLE, remaining=0.
- Reset asserted mid-access aborts the access: no RAM write occurs, and the stall drops asynchronously.
- Non-memory op: latched at edge t, in W after edge t+1; total EX→W latency is 2 edges.
- Memory op: latched at edge t; stallM high from after edge t until after edge t+MEM_LATENCY-1; in W after edge t+MEM_LATENCY.
- With MEM_LATENCY=1, stallM never asserts and memory ops behave like ALU ops.
- A store at edge k is visible to a load leaving M at any edge after k. This covers back-to-back store→load to the same address.
- A new bundle is accepted on the same edge the previous instruction leaves M, so there are no dead cycles between ops.

## Test plan
- Reset: assert reset mid-stream → all outputs 0 and stallM=0 immediately. After release, an ALU op (AluOutE=32'h1234, writeRegE=5, RegWriteE=1) → W shows 32'h1234, reg 5, RegWriteW=1 two edges after issue.
- Latency, MEM_LATENCY=3:
  - Store 32'hDEADBEEF to address 0x10 → stallM high for exactly 2 cycles; W carries a bubble in those cycles.
  - Then a load from 0x10 → ReadDataW=32'hDEADBEEF, MemToRegW=1.
- Wrap and misalignment, DEPTH=256: store 32'hA5A5A5A5 at address 0x400 → load from 0x0 returns it. Load from 0x403 → same word.
- Back-to-back, MEM_LATENCY=1: store 32'h1 @0x8, then load @0x8 in the next cycle → ReadDataW=32'h1, no stall, no gap.
- Bubble: validE=0 with MemWriteE=1 → RAM unchanged, stallM stays 0, validW=0 next cycle.
- Reset during BUSY: a store is in flight and reset asserts → a later load of that address returns the prior contents, and stallM=0 immediately.
